// File: rtl/video_out_stage.sv
// Final pixel output register for the VGA pins: colour depth expansion, delayed
// sync/blank alignment, optional blanking and sync polarity auto-detection.
module video_out_stage #(
  parameter int COLOR_DEPTH   = 6,
  parameter int OUT_DEPTH     = 6,
  parameter int SYNC_DELAY    = 0,
  parameter int SYNC_AND      = 0,
  parameter int POL_CNT_WIDTH = 12
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [COLOR_DEPTH-1:0] R,
  input  logic [COLOR_DEPTH-1:0] G,
  input  logic [COLOR_DEPTH-1:0] B,
  input  logic                   HSync,
  input  logic                   VSync,
  input  logic                   HBlank,
  input  logic                   VBlank,
  input  logic                   blank_en,
  input  logic                   csync_en,
  output logic [OUT_DEPTH-1:0]   VGA_R,
  output logic [OUT_DEPTH-1:0]   VGA_G,
  output logic [OUT_DEPTH-1:0]   VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   hs_pol,
  output logic                   vs_pol
);

  localparam logic [POL_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [POL_CNT_WIDTH-1:0] CNT_ONE = POL_CNT_WIDTH'(1);

  logic [3:0] sync_in;
  logic [3:0] sync_d;
  logic       hs_d, vs_d, hb_d, vb_d;

  assign sync_in = {HSync, VSync, HBlank, VBlank};

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign sync_d = sync_in;
    end else begin : g_delay
      logic [3:0] dly_q [SYNC_DELAY];
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          for (int i = 0; i < SYNC_DELAY; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= sync_in;
          for (int i = 1; i < SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign sync_d = dly_q[SYNC_DELAY-1];
    end
  endgenerate

  assign {hs_d, vs_d, hb_d, vb_d} = sync_d;

  // Left-justify and fill the low bits by cycling through the input MSBs.
  function automatic logic [OUT_DEPTH-1:0] expand(input logic [COLOR_DEPTH-1:0] c);
    logic [OUT_DEPTH-1:0] e;
    e = '0;
    for (int i = 0; i < OUT_DEPTH; i++) e[OUT_DEPTH-1-i] = c[COLOR_DEPTH-1-(i % COLOR_DEPTH)];
    return e;
  endfunction

  logic [POL_CNT_WIDTH-1:0] h_hi_q, h_hi_d, h_lo_q, h_lo_d;
  logic [POL_CNT_WIDTH-1:0] v_hi_q, v_hi_d, v_lo_q, v_lo_d;
  logic                     hs_prev_q, vs_prev_q;
  logic                     hs_pol_q, hs_pol_d, vs_pol_q, vs_pol_d;
  logic                     h_rise, v_rise;
  logic                     hs_a, vs_a, cs_n, blank;
  logic [OUT_DEPTH-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic                     vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;

  always_comb begin
    h_rise   = hs_d & ~hs_prev_q;
    v_rise   = vs_d & ~vs_prev_q;
    hs_pol_d = hs_pol_q;
    vs_pol_d = vs_pol_q;
    h_hi_d   = h_hi_q;
    h_lo_d   = h_lo_q;
    v_hi_d   = v_hi_q;
    v_lo_d   = v_lo_q;

    // The longer phase of a period is the inactive level of the sync.
    if (h_rise) begin
      if (h_hi_q > h_lo_q)      hs_pol_d = 1'b0;
      else if (h_lo_q > h_hi_q) hs_pol_d = 1'b1;
      h_hi_d = CNT_ONE;
      h_lo_d = '0;
    end else if (hs_d) begin
      if (h_hi_q != CNT_MAX) h_hi_d = h_hi_q + CNT_ONE;
    end else begin
      if (h_lo_q != CNT_MAX) h_lo_d = h_lo_q + CNT_ONE;
    end

    // Vertical counters count lines, so they only advance on HSync rising edges.
    if (v_rise) begin
      if (v_hi_q > v_lo_q)      vs_pol_d = 1'b0;
      else if (v_lo_q > v_hi_q) vs_pol_d = 1'b1;
      v_hi_d = h_rise ? CNT_ONE : '0;
      v_lo_d = '0;
    end else if (h_rise) begin
      if (vs_d) begin
        if (v_hi_q != CNT_MAX) v_hi_d = v_hi_q + CNT_ONE;
      end else begin
        if (v_lo_q != CNT_MAX) v_lo_d = v_lo_q + CNT_ONE;
      end
    end

    hs_a     = hs_pol_q ? hs_d : ~hs_d;
    vs_a     = vs_pol_q ? vs_d : ~vs_d;
    cs_n     = (SYNC_AND != 0) ? (~hs_a & ~vs_a) : ~(hs_a ^ vs_a);
    blank    = blank_en & (hb_d | vb_d);
    r_d      = blank ? '0 : expand(R);
    g_d      = blank ? '0 : expand(G);
    b_d      = blank ? '0 : expand(B);
    vga_hs_d = csync_en ? cs_n : ~hs_a;
    vga_vs_d = csync_en ? 1'b1 : ~vs_a;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      h_hi_q    <= '0;
      h_lo_q    <= '0;
      v_hi_q    <= '0;
      v_lo_q    <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      hs_pol_q  <= 1'b0;
      vs_pol_q  <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      vga_hs_q  <= 1'b1;
      vga_vs_q  <= 1'b1;
    end else begin
      h_hi_q    <= h_hi_d;
      h_lo_q    <= h_lo_d;
      v_hi_q    <= v_hi_d;
      v_lo_q    <= v_lo_d;
      hs_prev_q <= hs_d;
      vs_prev_q <= vs_d;
      hs_pol_q  <= hs_pol_d;
      vs_pol_q  <= vs_pol_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      vga_hs_q  <= vga_hs_d;
      vga_vs_q  <= vga_vs_d;
    end
  end

  assign VGA_R  = r_q;
  assign VGA_G  = g_q;
  assign VGA_B  = b_q;
  assign VGA_HS = vga_hs_q;
  assign VGA_VS = vga_vs_q;
  assign hs_pol = hs_pol_q;
  assign vs_pol = vs_pol_q;

endmodule

// File: tb/tb_video_out_stage.sv
// Bench for video_out_stage (4-bit in, 6-bit out, sync delay 3, XNOR composite sync):
// cycle reference model feeding an expected queue, plus scenario checks.
module tb_video_out_stage;

  localparam int CD   = 4;
  localparam int OD   = 6;
  localparam int SD   = 3;
  localparam int W    = 3 * OD + 4;
  localparam int CMAX = 4095;
  localparam logic [W-1:0] RST_OBS = {18'b0, 2'b11, 2'b00};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CD-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          hs_in = 1'b1, vs_in = 1'b1, hb_in = 1'b0, vb_in = 1'b0;
  logic          blank_en = 1'b0, csync_en = 1'b0;
  logic [OD-1:0] vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, hs_pol, vs_pol;
  logic [W-1:0]  obs;

  logic [W-1:0]  exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;

  video_out_stage #(
    .COLOR_DEPTH(CD), .OUT_DEPTH(OD), .SYNC_DELAY(SD), .SYNC_AND(0), .POL_CNT_WIDTH(12)
  ) dut (
    .clk_sys(clk), .reset(reset),
    .R(r_in), .G(g_in), .B(b_in),
    .HSync(hs_in), .VSync(vs_in), .HBlank(hb_in), .VBlank(vb_in),
    .blank_en(blank_en), .csync_en(csync_en),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .hs_pol(hs_pol), .vs_pol(vs_pol)
  );

  assign obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs, hs_pol, vs_pol};

  // clock
  always #5 clk = ~clk;

  // reference model: history of sync inputs plus polarity learning state
  logic [3:0] hist [SD];
  int         m_hhi, m_hlo, m_vhi, m_vlo;
  logic       m_hpol, m_vpol, m_hprev, m_vprev;

  initial begin
    logic dh, dv, dhb, dvb, bl, ha, va, ehs, evs, hrise, vrise;
    logic [OD-1:0] er, eg, eb;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < SD; i++) hist[i] = 4'b0;
        m_hhi = 0; m_hlo = 0; m_vhi = 0; m_vlo = 0;
        m_hpol = 0; m_vpol = 0; m_hprev = 0; m_vprev = 0;
        exp_q.push_back(RST_OBS);
      end else begin
        {dh, dv, dhb, dvb} = hist[SD-1];
        bl = blank_en && (dhb || dvb);
        er = bl ? 6'b0 : {r_in, r_in[3:2]};
        eg = bl ? 6'b0 : {g_in, g_in[3:2]};
        eb = bl ? 6'b0 : {b_in, b_in[3:2]};
        ha = m_hpol ? dh : !dh;
        va = m_vpol ? dv : !dv;
        if (csync_en) begin ehs = !(ha ^ va); evs = 1'b1; end
        else begin ehs = !ha; evs = !va; end
        hrise = dh && !m_hprev;
        vrise = dv && !m_vprev;
        if (hrise) begin
          if (m_hhi > m_hlo) m_hpol = 0; else if (m_hlo > m_hhi) m_hpol = 1;
          m_hhi = 1; m_hlo = 0;
        end else if (dh) m_hhi = (m_hhi < CMAX) ? m_hhi + 1 : CMAX;
        else m_hlo = (m_hlo < CMAX) ? m_hlo + 1 : CMAX;
        if (vrise) begin
          if (m_vhi > m_vlo) m_vpol = 0; else if (m_vlo > m_vhi) m_vpol = 1;
          m_vhi = hrise ? 1 : 0; m_vlo = 0;
        end else if (hrise) begin
          if (dv) m_vhi = (m_vhi < CMAX) ? m_vhi + 1 : CMAX;
          else m_vlo = (m_vlo < CMAX) ? m_vlo + 1 : CMAX;
        end
        m_hprev = dh; m_vprev = dv;
        for (int i = SD - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {hs_in, vs_in, hb_in, vb_in};
        exp_q.push_back({er, eg, eb, ehs, evs, m_hpol, m_vpol});
      end
    end
  end

  // driver: current inputs are sampled at the next edge; returns that edge's expectation
  task automatic drive_cycle(output logic [W-1:0] e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(e);
      n_vec++;
      if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_reset got %h want %h", obs, e); end
    end
    reset = 1'b0; r_in = 4'hF; g_in = 4'hF; b_in = 4'hF;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(e);
      n_vec++;
      if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_reset got %h want %h", obs, e); end
    end
    reset = 1'b1;
    drive_cycle(e);
    n_vec++;
    if (obs !== RST_OBS) begin n_bad++; $display("FAIL reset_values got %h want %h", obs, RST_OBS); end
    reset = 1'b0;
    drive_cycle(e);
    n_vec++;
    if (vga_r !== 6'h3F) begin n_bad++; $display("FAIL reset_resume got %h want %h", vga_r, 6'h3F); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(e);
      n_vec++;
      if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_reset got %h want %h", obs, e); end
    end
  endtask

  task automatic test_expand_latency();
    logic [W-1:0] e;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 40; c++) begin
        hs_in = (c < 5) ? 1'b0 : 1'b1;
        if (l == 3 && c == 0) begin r_in = 4'hB; g_in = 4'h5; b_in = 4'h0; end
        drive_cycle(e);
        n_vec++;
        if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_expand got %h want %h", obs, e); end
        if (l == 3 && c == 0) begin
          n_vec++;
          if ({vga_r, vga_g, vga_b} !== {6'h2E, 6'h15, 6'h00}) begin
            n_bad++; $display("FAIL expand_rgb got %h want %h", {vga_r, vga_g, vga_b}, {6'h2E, 6'h15, 6'h00});
          end
        end
        if (l == 3 && c == 2) begin
          n_vec++;
          if (vga_hs !== 1'b1) begin n_bad++; $display("FAIL hs_early got %b want 1", vga_hs); end
        end
        if (l == 3 && c == 3) begin
          n_vec++;
          if (vga_hs !== 1'b0) begin n_bad++; $display("FAIL hs_latency got %b want 0", vga_hs); end
        end
      end
    end
  endtask

  task automatic test_hpol_high();
    logic [W-1:0] e;
    int lows;
    lows = 0;
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 100; c++) begin
        hs_in = (c < 8) ? 1'b1 : 1'b0;
        drive_cycle(e);
        n_vec++;
        if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_hpol got %h want %h", obs, e); end
        if (l == 5 && vga_hs == 1'b0) lows++;
      end
    end
    n_vec++;
    if (hs_pol !== 1'b1) begin n_bad++; $display("FAIL hpol_high got %b want 1", hs_pol); end
    n_vec++;
    if (lows != 8) begin n_bad++; $display("FAIL hs_low_width got %0d want 8", lows); end
  endtask

  task automatic test_vpol_low();
    logic [W-1:0] e;
    int lows;
    lows = 0;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 262; l++) begin
        for (int c = 0; c < 20; c++) begin
          hs_in = (c < 2) ? 1'b0 : 1'b1;
          vs_in = (l < 3) ? 1'b0 : 1'b1;
          drive_cycle(e);
          n_vec++;
          if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_vpol got %h want %h", obs, e); end
          if (f == 1 && vga_vs == 1'b0) lows++;
        end
      end
    end
    n_vec++;
    if (vs_pol !== 1'b0) begin n_bad++; $display("FAIL vpol_low got %b want 0", vs_pol); end
    n_vec++;
    if (hs_pol !== 1'b0) begin n_bad++; $display("FAIL hpol_relearn got %b want 0", hs_pol); end
    n_vec++;
    if (lows != 60) begin n_bad++; $display("FAIL vs_low_width got %0d want 60", lows); end
  endtask

  task automatic test_csync();
    logic [W-1:0] e;
    int vs_bad, n;
    vs_bad = 0;
    csync_en = 1'b1;
    for (int l = 0; l < 10; l++) begin
      for (int c = 0; c < 20; c++) begin
        n = l * 20 + c;
        hs_in = (c < 2) ? 1'b0 : 1'b1;
        vs_in = (l >= 3 && l < 6) ? 1'b0 : 1'b1;
        drive_cycle(e);
        n_vec++;
        if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_csync got %h want %h", obs, e); end
        if (vga_vs !== 1'b1) vs_bad++;
        if (n == 83 || n == 93 || n == 23 || n == 33) begin
          n_vec++;
          if (vga_hs !== ((n == 83 || n == 33) ? 1'b1 : 1'b0)) begin
            n_bad++; $display("FAIL csync_n%0d got %b want %b", n, vga_hs, (n == 83 || n == 33));
          end
        end
      end
    end
    n_vec++;
    if (vs_bad != 0) begin n_bad++; $display("FAIL csync_vs_high got %0d non-1 cycles want 0", vs_bad); end
    csync_en = 1'b0;
  endtask

  task automatic test_blank();
    logic [W-1:0] e;
    int zeros, first;
    hs_in = 1'b1; vs_in = 1'b1;
    r_in = 4'hF; g_in = 4'hF; b_in = 4'hF;
    for (int ph = 0; ph < 3; ph++) begin
      blank_en = (ph != 2);
      zeros = 0; first = -1;
      for (int n = 0; n < 60; n++) begin
        hb_in = (ph != 1) && (n >= 10 && n < 30);
        vb_in = (ph == 1) && (n >= 10 && n < 15);
        drive_cycle(e);
        n_vec++;
        if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_blank got %h want %h", obs, e); end
        if ({vga_r, vga_g, vga_b} == 18'b0) begin
          zeros++;
          if (first < 0) first = n;
        end
      end
      n_vec++;
      if (zeros != ((ph == 0) ? 20 : (ph == 1) ? 5 : 0)) begin
        n_bad++; $display("FAIL blank_count_ph%0d got %0d want %0d", ph, zeros, (ph == 0) ? 20 : (ph == 1) ? 5 : 0);
      end
      if (ph == 0) begin
        n_vec++;
        if (first != 13) begin n_bad++; $display("FAIL blank_start got %0d want 13", first); end
      end
    end
    hb_in = 1'b0; vb_in = 1'b0; blank_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    for (int n = 0; n < 400; n++) begin
      r_in = CD'($urandom_range(0, 15));
      g_in = CD'($urandom_range(0, 15));
      b_in = CD'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) hs_in = ~hs_in;
      if ($urandom_range(0, 20) == 0) vs_in = ~vs_in;
      hb_in = ($urandom_range(0, 3) == 0);
      vb_in = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
      if ($urandom_range(0, 15) == 0) csync_en = ~csync_en;
      reset = ($urandom_range(0, 99) == 0);
      drive_cycle(e);
      n_vec++;
      if (obs !== e) begin n_bad++; if (n_bad <= 20) $display("FAIL sb_random got %h want %h", obs, e); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_expand_latency();
    test_hpol_high();
    test_vpol_low();
    test_csync();
    test_blank();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL queue_drain got %0d left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/video_out_stage.md
Name: video_out_stage

Overview:
Final pixel output stage for the MiST video path, placed after the scandoubler/OSD/cofi/YPbPr chain and before the VGA pins. It generalises the single-register output of the existing pipeline in four ways:
- parametrised input/output colour depth, with bit-replication expansion;
- a sync/blank delay line so sync stays aligned with the pipelined pixel data;
- explicit blanking from HBlank/VBlank inputs;
- automatic H/V sync polarity detection, so composite and separate syncs are always generated with the correct polarity.

Parameters:
COLOR_DEPTH, 6, input bits per colour channel (1-8).
OUT_DEPTH, 6, output bits per colour channel (COLOR_DEPTH to 8).
SYNC_DELAY, 0, clk_sys cycles by which HSync/VSync/HBlank/VBlank are delayed relative to R/G/B (0-15).
SYNC_AND, 0, composite sync mode: 0 = XNOR of syncs, 1 = AND of active-low syncs.
POL_CNT_WIDTH, 12, width of the saturating polarity-detect counters.

Ports:
clk_sys  in  1  master clock
reset  in  1  synchronous, active-high reset
R  in  COLOR_DEPTH  red, already pipelined by upstream
G  in  COLOR_DEPTH  green
B  in  COLOR_DEPTH  blue
HSync  in  1  horizontal sync, either polarity
VSync  in  1  vertical sync, either polarity
HBlank  in  1  horizontal blank, active-high
VBlank  in  1  vertical blank, active-high
blank_en  in  1  1 = force RGB to zero during blank
csync_en  in  1  1 = composite sync on VGA_HS, VGA_VS held at 1
VGA_R  out  OUT_DEPTH  red out
VGA_G  out  OUT_DEPTH  green out
VGA_B  out  OUT_DEPTH  blue out
VGA_HS  out  1  active-low HSync, or composite sync
VGA_VS  out  1  active-low VSync, or constant 1
hs_pol  out  1  detected HSync polarity, 1 = active-high
vs_pol  out  1  detected VSync polarity, 1 = active-high

Behaviour:
- The design is single-clock, and all state updates on posedge clk_sys. Reset is synchronous and active-high.
- Reset values:
  - VGA_R/G/B = 0; VGA_HS = 1; VGA_VS = 1.
  - hs_pol = vs_pol = 0.
  - Delay line is cleared to 0.
  - All counters are cleared to 0.
- Delay line:
  - The 4-bit vector {HSync, VSync, HBlank, VBlank} shifts through SYNC_DELAY stages every cycle (no clock enable).
  - With SYNC_DELAY = 0 the delay line is a wire. Its output is hs_d, vs_d, hb_d, vb_d.
- Latency:
  - R/G/B to VGA_R/G/B: 1 cycle.
  - Syncs/blanks to VGA_HS/VS and to blanking effect: SYNC_DELAY+1 cycles.
- Colour expansion:
  - Output = input bits left-justified, with the low OUT_DEPTH-COLOR_DEPTH bits filled by repeating the input MSBs.
  - Example: 4 to 6 bits, 4'b1011 becomes 6'b101110.
  - When OUT_DEPTH = COLOR_DEPTH the value passes through unchanged.
- Blanking: when blank_en=1 and (hb_d | vb_d)=1, the registered RGB is 0. Otherwise it is the expanded input.
- H polarity detect:
  - Counters hi_cnt and lo_cnt count cycles with hs_d=1 and hs_d=0 respectively. They saturate at all-ones.
  - On each hs_d rising edge (hs_d=1 while prior hs_d=0):
    - if hi_cnt > lo_cnt, hs_pol becomes 0;
    - if lo_cnt > hi_cnt, hs_pol becomes 1;
    - if they are equal, hs_pol holds.
  - Both counters then restart. The edge cycle itself counts as 1 in hi_cnt, 0 in lo_cnt.
- V polarity detect:
  - Same algorithm as H, but counters increment only on hs_d rising edges (counting lines), evaluated on vs_d rising edges.
- Polarity timing and stuck syncs:
  - A new polarity takes effect on outputs from the cycle after the evaluating edge.
  - A sync held constant produces no edges, so its polarity holds indefinitely.
- Normalisation: hs_a = hs_pol ? hs_d : ~hs_d; vs_a likewise. Both are active-high internally.
- Sync outputs (registered):
  - Composite sync cs_n:
    - SYNC_AND=0: cs_n = ~(hs_a ^ vs_a).
    - SYNC_AND=1: cs_n = ~hs_a & ~vs_a.
  - csync_en=1: VGA_HS = cs_n, VGA_VS = 1.
  - csync_en=0: VGA_HS = ~hs_a, VGA_VS = ~vs_a.
- Mode changes: changing csync_en or blank_en takes effect on the next output register update, with no glitch filtering.
- Reset mid-frame:
  - Outputs return to reset values the next cycle, and the delay line is flushed.
  - Polarity is re-learned: the first full H period after reset gives the correct hs_pol. With hs_pol defaulting to 0, active-low sync is correct immediately.

Test Plan:
1. Reset asserted mid-line with RGB=6'h3F → next cycle VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, hs_pol=0; outputs resume 1 cycle after reset drops.
2. COLOR_DEPTH=4, OUT_DEPTH=6, SYNC_DELAY=3, R=4'hB applied together with an HSync pulse → VGA_R=6'h2E after 1 cycle; VGA_HS falls after 4 cycles.
3. Active-high HSync, period 100 cycles, high 8 → hs_pol becomes 1 after the second rising edge; thereafter VGA_HS is low exactly 8 cycles per line.
4. Active-low VSync: low 3 lines, frame 262 lines, HSync active-low → vs_pol stays 0; VGA_VS is low for exactly 3 lines.
5. csync_en=1, SYNC_AND=0, both syncs active-low and overlapping → VGA_VS constantly 1; VGA_HS inverted (high) during HSync pulses inside the VSync window (serration).
6. blank_en=1, HBlank pulse of 20 cycles, SYNC_DELAY=2, RGB=all-ones → exactly 20 zero output pixels, starting 3 cycles after HBlank rises; blank_en=0 → no zeros.
